// File: rtl/pixel_loader.sv
// Pixel loader: accepts a raster-ordered pixel stream through a small FIFO
// and writes each pixel into an image memory at (row, col), with a write
// port that can be stalled while the controller reads the window.
module pixel_loader #(
    parameter int IMG_ROWS   = 64,
    parameter int IMG_COLS   = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       in_valid,
    input  logic [7:0] in_pixel,
    output logic       in_ready,
    input  logic       wr_stall,
    output logic       wr,
    output logic [7:0] addr_row_w,
    output logic [7:0] addr_col_w,
    output logic [7:0] wr_pixel,
    output logic       busy,
    output logic       frame_done
);

    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [16:0] TOTAL_PIX = 17'(IMG_ROWS * IMG_COLS);
    localparam logic [16:0] LAST_PIX  = TOTAL_PIX - 17'd1;
    localparam logic [7:0]  LAST_ROW  = 8'(IMG_ROWS - 1);
    localparam logic [7:0]  LAST_COL  = 8'(IMG_COLS - 1);
    localparam logic [AW:0] OCC_FULL  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0] OCC_ZERO  = (AW + 1)'(0);
    localparam logic [AW:0] OCC_ONE   = (AW + 1)'(1);
    localparam logic [AW-1:0] IDX_ONE = AW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q;
    logic          busy_q;
    logic          frame_done_q;

    logic [7:0]    fifo_mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_idx_q;
    logic [AW-1:0] rd_idx_q;
    logic [AW:0]   occ_q;
    logic [AW:0]   occ_d;

    logic [16:0]   pix_cnt_q;
    logic [7:0]    row_ptr_q;
    logic [7:0]    row_ptr_d;
    logic [7:0]    col_ptr_q;
    logic [7:0]    col_ptr_d;

    logic          wr_q;
    logic [7:0]    addr_row_q;
    logic [7:0]    addr_col_q;
    logic [7:0]    wr_pixel_q;

    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic          start_s;
    logic          in_ready_s;
    logic          push_s;
    logic          pop_s;
    logic          last_px_s;
    logic          last_wr_s;

    // A full FIFO refuses pushes even when a pop frees a slot this cycle.
    assign fifo_full_s  = (occ_q == OCC_FULL);
    assign fifo_empty_s = (occ_q == OCC_ZERO);
    assign start_s      = (state_q == IDLE) && start;
    assign in_ready_s   = (state_q == LOAD) && !fifo_full_s;
    assign push_s       = in_valid && in_ready_s;
    assign pop_s        = !fifo_empty_s && !wr_stall &&
                          ((state_q == LOAD) || (state_q == DRAIN));
    assign last_px_s    = push_s && (pix_cnt_q == LAST_PIX);
    assign last_wr_s    = wr_q && (addr_row_q == LAST_ROW) && (addr_col_q == LAST_COL);

    assign in_ready   = in_ready_s;
    assign wr         = wr_q;
    assign addr_row_w = addr_row_q;
    assign addr_col_w = addr_col_q;
    assign wr_pixel   = wr_pixel_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

    // Next FIFO occupancy and next raster write position.
    always_comb begin
        occ_d     = occ_q;
        row_ptr_d = row_ptr_q;
        col_ptr_d = col_ptr_q;
        if (push_s && !pop_s) begin
            occ_d = occ_q + OCC_ONE;
        end else if (pop_s && !push_s) begin
            occ_d = occ_q - OCC_ONE;
        end else begin
            occ_d = occ_q;
        end
        if (start_s) begin
            row_ptr_d = 8'd0;
            col_ptr_d = 8'd0;
        end else if (pop_s) begin
            if (col_ptr_q == LAST_COL) begin
                col_ptr_d = 8'd0;
                row_ptr_d = (row_ptr_q == LAST_ROW) ? row_ptr_q : row_ptr_q + 8'd1;
            end else begin
                col_ptr_d = col_ptr_q + 8'd1;
            end
        end else begin
            row_ptr_d = row_ptr_q;
            col_ptr_d = col_ptr_q;
        end
    end

    // Frame FSM with its registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= LOAD;
                        busy_q  <= 1'b1;
                    end
                    frame_done_q <= 1'b0;
                end
                LOAD: begin
                    if (last_px_s) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (last_wr_s) begin
                        state_q      <= DONE;
                        busy_q       <= 1'b0;
                        frame_done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q      <= IDLE;
                    busy_q       <= 1'b0;
                    frame_done_q <= 1'b0;
                end
                default: begin
                    state_q      <= IDLE;
                    busy_q       <= 1'b0;
                    frame_done_q <= 1'b0;
                end
            endcase
        end
    end

    // FIFO storage; contents are only meaningful between the indices.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_q[wr_idx_q] <= in_pixel;
        end
    end

    // FIFO indices, pixel count, raster pointers and the write port registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
            occ_q      <= OCC_ZERO;
            pix_cnt_q  <= 17'd0;
            row_ptr_q  <= 8'd0;
            col_ptr_q  <= 8'd0;
            wr_q       <= 1'b0;
            addr_row_q <= 8'd0;
            addr_col_q <= 8'd0;
            wr_pixel_q <= 8'd0;
        end else begin
            occ_q     <= occ_d;
            row_ptr_q <= row_ptr_d;
            col_ptr_q <= col_ptr_d;
            if (push_s) begin
                wr_idx_q <= wr_idx_q + IDX_ONE;
            end
            if (pop_s) begin
                rd_idx_q   <= rd_idx_q + IDX_ONE;
                wr_pixel_q <= fifo_mem_q[rd_idx_q];
                addr_row_q <= row_ptr_q;
                addr_col_q <= col_ptr_q;
            end
            wr_q <= pop_s;
            if (start_s) begin
                pix_cnt_q <= 17'd0;
            end else if (push_s) begin
                pix_cnt_q <= pix_cnt_q + 17'd1;
            end
        end
    end

endmodule

// File: doc/pixel_loader.md
PIXEL_LOADER -- requirements
Module: pixel_loader

Interface
REQ-001 Parameter IMG_ROWS, default 64, image height in rows (legal range 1..256).
REQ-002 Parameter IMG_COLS, default 64, image width in columns (legal range 1..256).
REQ-003 Parameter FIFO_DEPTH, default 4, input buffer entries (power of two, at least 2).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse that begins loading one frame.
REQ-007 in_valid  input  1  source presents a pixel on in_pixel.
REQ-008 in_pixel  input  8  incoming pixel value.
REQ-009 in_ready  output  1  loader accepts a pixel this cycle.
REQ-010 wr_stall  input  1  memory write port unavailable this cycle, because the controller is reading the window.
REQ-011 wr  output  1  memory write strobe, registered.
REQ-012 addr_row_w  output  8  write row address, registered.
REQ-013 addr_col_w  output  8  write column address, registered.
REQ-014 wr_pixel  output  8  write data, registered.
REQ-015 busy  output  1  high in LOAD and DRAIN states.
REQ-016 frame_done  output  1  one-cycle pulse when the frame is fully written.

Function
REQ-017 The FSM SHALL have four states: IDLE, LOAD, DRAIN and DONE.
REQ-018 IDLE -> LOAD on start=1; start SHALL be ignored in all other states.
REQ-019 LOAD -> DRAIN on the cycle the (IMG_ROWS*IMG_COLS)-th pixel is accepted.
REQ-020 DRAIN -> DONE on the cycle wr is high with addr_row_w=IMG_ROWS-1 and addr_col_w=IMG_COLS-1.
REQ-021 DONE -> IDLE unconditionally after one cycle; frame_done SHALL be high only in DONE.
REQ-022 in_ready SHALL equal (state==LOAD) AND NOT fifo_full; a pixel is accepted when in_valid AND in_ready are both high.
REQ-023 A push SHALL be refused when the FIFO is full, even if a pop occurs in the same cycle.
REQ-024 The accepted-pixel count SHALL be 17 bits wide, cleared on the start pulse, and SHALL never exceed IMG_ROWS*IMG_COLS.
REQ-025 A pop SHALL occur in any cycle where the FIFO is non-empty, wr_stall=0 and the state is LOAD or DRAIN.
REQ-026 The cycle after a pop, wr SHALL be 1 with wr_pixel equal to the popped value; otherwise wr SHALL be 0.
REQ-027 wr_pixel and both addresses SHALL hold their last values while wr=0.
REQ-028 Latency: with an empty FIFO and wr_stall=0, a pixel accepted in cycle t SHALL appear with wr=1 in cycle t+2.
REQ-029 Simultaneous push and pop on a non-full FIFO SHALL leave the occupancy unchanged and preserve FIFO order.
REQ-030 Addressing is raster order: col_ptr increments after each write; at IMG_COLS-1 it wraps to 0 and row_ptr increments.
REQ-031 row_ptr SHALL not advance past IMG_ROWS-1.
REQ-032 The write for the Nth accepted pixel (N from 0) SHALL use row N/IMG_COLS and column N mod IMG_COLS.
REQ-033 wr_stall only delays pops; it SHALL cause no data loss, no duplication and no reordering.
REQ-034 Both pointers SHALL reset to 0 on the start pulse.

Reset
REQ-035 When rst=1 at a clock edge, the state SHALL be IDLE and the FIFO SHALL be empty.
REQ-036 When rst=1 at a clock edge, the pixel count, row_ptr and col_ptr SHALL be 0.
REQ-037 When rst=1 at a clock edge, outputs SHALL be: wr=0, addr_row_w=0, addr_col_w=0, wr_pixel=0, busy=0, frame_done=0, in_ready=0.
REQ-038 Reset mid-frame SHALL discard buffered pixels, issue no further writes and produce no frame_done pulse.

Verification (IMG_ROWS=2, IMG_COLS=3, FIFO_DEPTH=4)
REQ-039 Scenario 1: start, then pixels 10..15 streamed with in_valid=1 and wr_stall=0 -> six writes at (0,0),(0,1),(0,2),(1,0),(1,1),(1,2) with data 10..15; first write 2 cycles after first accept; frame_done pulses once, the cycle after the last write.
REQ-040 Scenario 2: wr_stall=1 held while 6 pixels are offered -> in_ready drops after 4 accepts; after wr_stall releases, all six writes occur in order with no gaps or duplicates.
REQ-041 Scenario 3: in_valid toggling 1,0,1,0 -> only pixels presented with in_valid=1 are written; addresses advance by exactly one per write.
REQ-042 Scenario 4: rst asserted after 3 writes -> next cycle wr=0, busy=0, all addresses 0; no frame_done; a following start reloads a full frame from address (0,0).
REQ-043 Scenario 5: start pulsed again during LOAD, and a 7th pixel offered after the 6th -> start ignored, in_ready=0 for the 7th pixel, exactly 6 writes.
REQ-044 Scenario 6: pixels offered with in_valid=1 in IDLE without start -> in_ready=0 and wr=0 throughout.
